// File: rtl/cpu_bus_initiator.sv
// 68030-style asynchronous bus master: turns single-transfer requests into AS_n/DS_n/RW/SIZ
// cycles terminated by DSACK. Define BUS_TIMEOUT_EN to add the WAIT-state timeout (bus error).
module cpu_bus_initiator #(
  parameter int ADDR_W         = 28,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic              REQ_RW,
  input  logic [1:0]        REQ_SIZ,
  input  logic [31:0]       REQ_WDATA,
  output logic              RSP_VALID,
  output logic [31:0]       RSP_RDATA,
  output logic [1:0]        RSP_PORT,
  output logic              RSP_ERR,
  output logic [ADDR_W-1:0] ADDR,
  output logic              SIZ0,
  output logic              SIZ1,
  output logic              RW,
  output logic              AS_n,
  output logic              DS_n,
  output logic [31:0]       D_OUT,
  output logic              D_OE,
  input  logic [31:0]       D_IN,
  input  logic              DSACK0_n,
  input  logic              DSACK1_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_PH,
    S_STROBE,
    S_WAIT,
    S_TERM
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [1:0]        r_dsack_p0;
  logic [1:0]        r_dsack_p1;
  logic              w_ack;
  logic              w_released;
  logic              w_accept;
  logic              w_timeout;

  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_siz;
  logic              r_rw;
  logic              r_as_n;
  logic              r_ds_n;
  logic [31:0]       r_d_out;
  logic              r_d_oe;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic [1:0]        r_rsp_port;
  logic              r_rsp_err;

  assign REQ_READY  = (r_state == S_IDLE) & ~RST;
  assign w_accept   = REQ_VALID & REQ_READY;
  assign w_ack      = ~&r_dsack_p1;
  assign w_released = &r_dsack_p1;

  // DSACK pins are asynchronous: sync stage p0 -> p1, decisions use p1 only ({DSACK1_n, DSACK0_n})
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_dsack_p0 <= 2'b11;
      r_dsack_p1 <= 2'b11;
    end else begin
      r_dsack_p0 <= {DSACK1_n, DSACK0_n};
      r_dsack_p1 <= r_dsack_p0;
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] r_wait_cnt;

  always_ff @(posedge CLK) begin
    if (RST || r_state != S_WAIT) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

  // Fires on the edge that would complete the TIMEOUT_CYCLES-th WAIT cycle
  assign w_timeout = (r_state == S_WAIT) && (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // No timeout: WAIT holds until a slave acknowledges; this folds to constant 0
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next_state = S_ADDR_PH;
      S_ADDR_PH: w_next_state = S_STROBE;
      S_STROBE:  w_next_state = S_WAIT;
      S_WAIT:    if (w_ack || w_timeout) w_next_state = S_TERM;
      S_TERM:    if (w_released) w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_addr      <= '0;
      r_siz       <= 2'b00;
      r_rw        <= 1'b1;
      r_as_n      <= 1'b1;
      r_ds_n      <= 1'b1;
      r_d_out     <= 32'h0;
      r_d_oe      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_port  <= 2'b00;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr <= REQ_ADDR;
            r_siz  <= REQ_SIZ;
            r_rw   <= REQ_RW;
            if (!REQ_RW) begin
              r_d_out <= REQ_WDATA;
              r_d_oe  <= 1'b1;
            end
          end
        end
        S_ADDR_PH: begin
          r_as_n <= 1'b0;
          if (r_rw) r_ds_n <= 1'b0;
        end
        S_STROBE: begin
          if (!r_rw) r_ds_n <= 1'b0;
        end
        S_WAIT: begin
          // D_IN has been stable for the two synchronizer cycles by the time ack is seen
          if (w_ack) begin
            if (r_rw) r_rsp_rdata <= D_IN;
            r_rsp_port <= ~r_dsack_p1;
            r_rsp_err  <= 1'b0;
            r_as_n     <= 1'b1;
            r_ds_n     <= 1'b1;
            r_d_oe     <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_rdata <= 32'hFFFF_FFFF;
            r_rsp_port  <= 2'b00;
            r_rsp_err   <= 1'b1;
            r_as_n      <= 1'b1;
            r_ds_n      <= 1'b1;
            r_d_oe      <= 1'b0;
          end
        end
        S_TERM: begin
          r_d_oe <= 1'b0;
          if (w_released) begin
            r_rsp_valid <= 1'b1;
            r_rw        <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ADDR      = r_addr;
  assign SIZ0      = r_siz[0];
  assign SIZ1      = r_siz[1];
  assign RW        = r_rw;
  assign AS_n      = r_as_n;
  assign DS_n      = r_ds_n;
  assign D_OUT     = r_d_out;
  assign D_OE      = r_d_oe;
  assign RSP_VALID = r_rsp_valid;
  assign RSP_RDATA = r_rsp_rdata;
  assign RSP_PORT  = r_rsp_port;
  assign RSP_ERR   = r_rsp_err;

endmodule

// File: tb/tb_cpu_bus_initiator.sv
// Bench for cpu_bus_initiator: directed and random transfers against a timing/data reference model.
module tb_cpu_bus_initiator;
  localparam int ADDR_W = 28;
  localparam int TMO    = 16;

  logic              CLK = 1'b0;
  logic              RST;
  logic              REQ_VALID;
  logic              REQ_READY;
  logic [ADDR_W-1:0] REQ_ADDR;
  logic              REQ_RW;
  logic [1:0]        REQ_SIZ;
  logic [31:0]       REQ_WDATA;
  logic              RSP_VALID;
  logic [31:0]       RSP_RDATA;
  logic [1:0]        RSP_PORT;
  logic              RSP_ERR;
  logic [ADDR_W-1:0] ADDR;
  logic              SIZ0, SIZ1, RW, AS_n, DS_n, D_OE;
  logic [31:0]       D_OUT;
  logic [31:0]       D_IN;
  logic              DSACK0_n, DSACK1_n;

  always #5 CLK = ~CLK;

  cpu_bus_initiator #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR),
    .REQ_RW(REQ_RW), .REQ_SIZ(REQ_SIZ), .REQ_WDATA(REQ_WDATA), .RSP_VALID(RSP_VALID),
    .RSP_RDATA(RSP_RDATA), .RSP_PORT(RSP_PORT), .RSP_ERR(RSP_ERR), .ADDR(ADDR), .SIZ0(SIZ0),
    .SIZ1(SIZ1), .RW(RW), .AS_n(AS_n), .DS_n(DS_n), .D_OUT(D_OUT), .D_OE(D_OE), .D_IN(D_IN),
    .DSACK0_n(DSACK0_n), .DSACK1_n(DSACK1_n)
  );

  int          n_vec;
  int          n_err;
  logic [31:0] exp_rdata;

  // Observations of one transfer; cycle numbers count rising edges since the request was presented
  int          o_acc, o_as_fall, o_ds_fall, o_as_rise, o_rsp, o_nvalid, o_ack_edge, o_rel_edge, o_end;
  logic [31:0] o_rdata;
  logic [1:0]  o_port;
  logic        o_err, o_bus_bad, o_busy_bad;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Presents one request, plays the slave (ack dly cycles after AS_n falls, release hold cycles
  // after AS_n rises; sport=00 means no slave answers) and records what the bus did.
  task automatic run_xfer(input logic rw, input logic [ADDR_W-1:0] addr, input logic [1:0] siz,
                          input logic [31:0] wdata, input logic [31:0] sdata, input logic [1:0] sport,
                          input int dly, input int hold, input bit keep, input int bound);
    int cyc;
    bit acked, rel;
    o_acc = -1; o_as_fall = -1; o_ds_fall = -1; o_as_rise = -1; o_rsp = -1; o_nvalid = 0;
    o_ack_edge = -1; o_rel_edge = -1; o_rdata = '0; o_port = '0; o_err = 1'b0;
    o_bus_bad = 1'b0; o_busy_bad = 1'b0;
    acked = 1'b0; rel = 1'b0; cyc = 0;
    @(negedge CLK);
    REQ_ADDR = addr; REQ_RW = rw; REQ_SIZ = siz; REQ_WDATA = wdata; REQ_VALID = 1'b1;
    if (REQ_READY === 1'b1) o_acc = 1;
    while (cyc < bound && (o_rsp < 0 || cyc < o_rsp + 1)) begin
      @(negedge CLK);
      cyc++;
      if (o_acc == cyc && !keep) REQ_VALID = 1'b0;
      if (o_acc < 0 && REQ_READY === 1'b1) o_acc = cyc + 1;
      if (o_acc > 0 && cyc >= o_acc) begin
        if (AS_n === 1'b0 && o_as_fall < 0) o_as_fall = cyc;
        if (DS_n === 1'b0 && o_ds_fall < 0) o_ds_fall = cyc;
        if (AS_n === 1'b1 && o_as_fall >= 0 && o_as_rise < 0) o_as_rise = cyc;
        if (RSP_VALID === 1'b1) begin
          o_nvalid++;
          if (o_rsp < 0) begin
            o_rsp = cyc; o_rdata = RSP_RDATA; o_port = RSP_PORT; o_err = RSP_ERR;
          end
        end
        if (ADDR !== addr || {SIZ1, SIZ0} !== siz) o_bus_bad = 1'b1;
        if (o_rsp < 0 && RW !== rw) o_bus_bad = 1'b1;
        if (cyc == o_rsp && RW !== 1'b1) o_bus_bad = 1'b1;
        if (DS_n === 1'b0 && AS_n === 1'b1) o_bus_bad = 1'b1;
        if (!rw && o_as_rise < 0 && (D_OE !== 1'b1 || D_OUT !== wdata)) o_bus_bad = 1'b1;
        if ((rw || cyc == o_rsp) && o_rsp <= cyc && (rw ? (o_rsp < 0 || cyc == o_rsp) : 1'b1)
            && D_OE !== 1'b0) o_bus_bad = 1'b1;
        if (o_rsp < 0 && REQ_READY !== 1'b0) o_busy_bad = 1'b1;
      end
      if (o_as_fall >= 0 && !acked && sport != 2'b00 && cyc >= o_as_fall + dly) begin
        DSACK1_n = ~sport[1]; DSACK0_n = ~sport[0]; D_IN = sdata;
        acked = 1'b1; o_ack_edge = cyc + 1;
      end
      if (acked && !rel && o_as_rise >= 0 && cyc >= o_as_rise + hold) begin
        DSACK1_n = 1'b1; DSACK0_n = 1'b1; D_IN = $urandom;
        rel = 1'b1; o_rel_edge = cyc + 1;
      end
    end
    if (!keep) REQ_VALID = 1'b0;
    o_end = cyc;
  endtask

  task automatic pulse_reset();
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    exp_rdata = 32'h0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    n_vec++; if (REQ_READY !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b expected 0", REQ_READY); end
    n_vec++; if ({AS_n, DS_n, RW, SIZ1, SIZ0, D_OE} !== 6'b111000) begin n_err++; $display("FAIL rst_bus: got %b expected 111000", {AS_n, DS_n, RW, SIZ1, SIZ0, D_OE}); end
    n_vec++; if ({RSP_VALID, RSP_ERR, RSP_PORT} !== 4'b0000) begin n_err++; $display("FAIL rst_rsp: got %b expected 0000", {RSP_VALID, RSP_ERR, RSP_PORT}); end
    n_vec++; if (ADDR !== '0 || D_OUT !== 32'h0) begin n_err++; $display("FAIL rst_addr_dout: got %h/%h expected 0/0", ADDR, D_OUT); end
    n_vec++; if (RSP_RDATA !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h expected 0", RSP_RDATA); end
    RST = 1'b0;
    #1;
    n_vec++; if (REQ_READY !== 1'b1) begin n_err++; $display("FAIL rst_ready_after: got %b expected 1", REQ_READY); end
  endtask

  task automatic test_read();
    int ea_fall, ea_rise, e_rsp;
    run_xfer(1'b1, 28'h0000100, 2'b00, 32'h0, 32'hDEADBEEF, 2'b11, 1, 0, 1'b0, 300);
    exp_rdata = 32'hDEADBEEF;
    ea_fall = o_acc + 1;
    ea_rise = imax(o_ack_edge + 2, ea_fall + 2);
    e_rsp   = imax(o_rel_edge + 2, ea_rise + 1);
    n_vec++; if (o_nvalid != 1) begin n_err++; $display("FAIL read_nvalid: got %0d expected 1", o_nvalid); end
    n_vec++; if (o_rdata !== exp_rdata) begin n_err++; $display("FAIL read_rdata: got %h expected %h", o_rdata, exp_rdata); end
    n_vec++; if (o_port !== 2'b11 || o_err !== 1'b0) begin n_err++; $display("FAIL read_port_err: got %b/%b expected 11/0", o_port, o_err); end
    n_vec++; if (o_as_fall != ea_fall || o_ds_fall != ea_fall) begin n_err++; $display("FAIL read_strobe_fall: got as=%0d ds=%0d expected %0d", o_as_fall, o_ds_fall, ea_fall); end
    n_vec++; if (o_as_rise != ea_rise) begin n_err++; $display("FAIL read_as_rise: got %0d expected %0d", o_as_rise, ea_rise); end
    n_vec++; if (o_rsp != e_rsp) begin n_err++; $display("FAIL read_rsp_cycle: got %0d expected %0d", o_rsp, e_rsp); end
    n_vec++; if (o_bus_bad || o_busy_bad) begin n_err++; $display("FAIL read_bus: got bus=%b busy=%b expected 0/0", o_bus_bad, o_busy_bad); end
  endtask

  task automatic test_write();
    int ea_fall, ea_rise, e_rsp;
    run_xfer(1'b0, 28'h0000200, 2'b00, 32'h12345678, 32'h0BADF00D, 2'b11, 1, 0, 1'b0, 300);
    ea_fall = o_acc + 1;
    ea_rise = imax(o_ack_edge + 2, ea_fall + 2);
    e_rsp   = imax(o_rel_edge + 2, ea_rise + 1);
    n_vec++; if (o_ds_fall != o_as_fall + 1 || o_as_fall != ea_fall) begin n_err++; $display("FAIL write_ds_after_as: got as=%0d ds=%0d expected %0d/%0d", o_as_fall, o_ds_fall, ea_fall, ea_fall + 1); end
    n_vec++; if (o_bus_bad) begin n_err++; $display("FAIL write_bus_doe_dout_rw: got %b expected 0", o_bus_bad); end
    n_vec++; if (o_port !== 2'b11 || o_nvalid != 1) begin n_err++; $display("FAIL write_port_valid: got %b/%0d expected 11/1", o_port, o_nvalid); end
    n_vec++; if (o_rdata !== exp_rdata) begin n_err++; $display("FAIL write_rdata_held: got %h expected %h", o_rdata, exp_rdata); end
    n_vec++; if (o_rsp != e_rsp) begin n_err++; $display("FAIL write_rsp_cycle: got %0d expected %0d", o_rsp, e_rsp); end
  endtask

  task automatic test_port_width();
    run_xfer(1'b1, 28'h0ABC000, 2'b10, 32'h0, 32'h0000CAFE, 2'b10, 0, 1, 1'b0, 300);
    exp_rdata = 32'h0000CAFE;
    n_vec++; if (o_port !== 2'b10 || o_rdata !== exp_rdata) begin n_err++; $display("FAIL port16: got %b/%h expected 10/%h", o_port, o_rdata, exp_rdata); end
    run_xfer(1'b0, 28'h0ABC001, 2'b01, 32'h000000A5, 32'h0, 2'b01, 2, 0, 1'b0, 300);
    n_vec++; if (o_port !== 2'b01 || o_rdata !== exp_rdata) begin n_err++; $display("FAIL port8: got %b/%h expected 01/%h", o_port, o_rdata, exp_rdata); end
  endtask

  task automatic test_back_to_back();
    int ea_fall, ea_rise, e_rsp, cyc, as2;
    run_xfer(1'b1, 28'h0000300, 2'b11, 32'h0, 32'h5A5A1234, 2'b11, 0, 5, 1'b1, 300);
    exp_rdata = 32'h5A5A1234;
    ea_fall = o_acc + 1;
    ea_rise = imax(o_ack_edge + 2, ea_fall + 2);
    e_rsp   = imax(o_rel_edge + 2, ea_rise + 1);
    n_vec++; if (o_rsp != e_rsp || o_nvalid != 1) begin n_err++; $display("FAIL b2b_rsp_waits_release: got %0d/%0d expected %0d/1", o_rsp, o_nvalid, e_rsp); end
    n_vec++; if (o_busy_bad) begin n_err++; $display("FAIL b2b_busy_ready: got %b expected 0", o_busy_bad); end
    n_vec++; if (o_rdata !== exp_rdata) begin n_err++; $display("FAIL b2b_rdata: got %h expected %h", o_rdata, exp_rdata); end
    cyc = o_end; as2 = -1;
    REQ_VALID = 1'b0;
    while (as2 < 0 && cyc < o_end + 20) begin
      @(negedge CLK);
      cyc++;
      if (AS_n === 1'b0) as2 = cyc;
    end
    n_vec++; if (as2 != o_rsp + 2) begin n_err++; $display("FAIL b2b_second_as: got %0d expected %0d", as2, o_rsp + 2); end
    pulse_reset();
  endtask

  task automatic test_rst_in_wait();
    int seen;
    run_xfer(1'b0, 28'h0000400, 2'b00, 32'hA5A5C3C3, 32'h0, 2'b00, 0, 0, 1'b0, 8);
    n_vec++; if (AS_n !== 1'b0 || D_OE !== 1'b1 || o_rsp >= 0) begin n_err++; $display("FAIL rstw_in_wait: got as=%b oe=%b rsp=%0d expected 0/1/-1", AS_n, D_OE, o_rsp); end
    RST = 1'b1;
    @(negedge CLK);
    n_vec++; if ({AS_n, DS_n, D_OE, RSP_VALID} !== 4'b1100) begin n_err++; $display("FAIL rstw_bus: got %b expected 1100", {AS_n, DS_n, D_OE, RSP_VALID}); end
    n_vec++; if (REQ_READY !== 1'b0 || RSP_RDATA !== 32'h0) begin n_err++; $display("FAIL rstw_ready_rdata: got %b/%h expected 0/0", REQ_READY, RSP_RDATA); end
    RST = 1'b0;
    exp_rdata = 32'h0;
    #1;
    n_vec++; if (REQ_READY !== 1'b1) begin n_err++; $display("FAIL rstw_ready_after: got %b expected 1", REQ_READY); end
    seen = 0;
    repeat (6) begin @(negedge CLK); if (RSP_VALID === 1'b1) seen++; end
    n_vec++; if (seen != 0) begin n_err++; $display("FAIL rstw_no_rsp: got %0d expected 0", seen); end
  endtask

`ifdef BUS_TIMEOUT_EN
  task automatic test_timeout();
    int ea_fall, ea_rise;
    run_xfer(1'b1, 28'h0000500, 2'b00, 32'h0, 32'h0, 2'b00, 0, 0, 1'b0, 200);
    exp_rdata = 32'hFFFF_FFFF;
    ea_fall = o_acc + 1;
    ea_rise = ea_fall + 1 + TMO;
    n_vec++; if (o_as_rise != ea_rise) begin n_err++; $display("FAIL tmo_as_rise: got %0d expected %0d", o_as_rise, ea_rise); end
    n_vec++; if (o_rsp != ea_rise + 1 || o_nvalid != 1) begin n_err++; $display("FAIL tmo_rsp: got %0d/%0d expected %0d/1", o_rsp, o_nvalid, ea_rise + 1); end
    n_vec++; if (o_err !== 1'b1 || o_port !== 2'b00 || o_rdata !== exp_rdata) begin n_err++; $display("FAIL tmo_fields: got %b/%b/%h expected 1/00/%h", o_err, o_port, o_rdata, exp_rdata); end
    run_xfer(1'b1, 28'h0000504, 2'b00, 32'h0, 32'h600DD00D, 2'b11, TMO - 2, 0, 1'b0, 200);
    exp_rdata = 32'h600DD00D;
    ea_fall = o_acc + 1;
    n_vec++; if (o_as_rise != ea_fall + 1 + TMO) begin n_err++; $display("FAIL tmo_tie_cycle: got %0d expected %0d", o_as_rise, ea_fall + 1 + TMO); end
    n_vec++; if (o_err !== 1'b0 || o_port !== 2'b11 || o_rdata !== exp_rdata) begin n_err++; $display("FAIL tmo_tie_ack_wins: got %b/%b/%h expected 0/11/%h", o_err, o_port, o_rdata, exp_rdata); end
  endtask
`else
  task automatic test_no_timeout();
    run_xfer(1'b1, 28'h0000500, 2'b00, 32'h0, 32'h0, 2'b00, 0, 0, 1'b0, 1000);
    n_vec++; if (o_rsp >= 0 || o_nvalid != 0) begin n_err++; $display("FAIL notmo_rsp: got %0d/%0d expected -1/0", o_rsp, o_nvalid); end
    n_vec++; if (AS_n !== 1'b0 || DS_n !== 1'b0) begin n_err++; $display("FAIL notmo_still_wait: got %b%b expected 00", AS_n, DS_n); end
    pulse_reset();
  endtask
`endif

  task automatic test_random();
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        siz, sport;
    logic [31:0]       wdata, sdata;
    int                dly, hold, ea_fall, ea_ds, ea_rise, e_rsp;
    for (int i = 0; i < 16; i++) begin
      rw = 1'($urandom); addr = ADDR_W'($urandom); siz = 2'($urandom);
      wdata = $urandom; sdata = $urandom;
      case ($urandom_range(0, 2))
        0:       sport = 2'b11;
        1:       sport = 2'b10;
        default: sport = 2'b01;
      endcase
      dly = $urandom_range(0, 4); hold = $urandom_range(0, 3);
      run_xfer(rw, addr, siz, wdata, sdata, sport, dly, hold, 1'b0, 300);
      if (rw) exp_rdata = sdata;
      ea_fall = o_acc + 1;
      ea_ds   = rw ? ea_fall : ea_fall + 1;
      ea_rise = imax(o_ack_edge + 2, ea_fall + 2);
      e_rsp   = imax(o_rel_edge + 2, ea_rise + 1);
      n_vec++; if (o_nvalid != 1 || o_rsp != e_rsp) begin n_err++; $display("FAIL rnd%0d_rsp: got %0d@%0d expected 1@%0d", i, o_nvalid, o_rsp, e_rsp); end
      n_vec++; if (o_as_fall != ea_fall || o_ds_fall != ea_ds || o_as_rise != ea_rise) begin n_err++; $display("FAIL rnd%0d_strobes: got %0d/%0d/%0d expected %0d/%0d/%0d", i, o_as_fall, o_ds_fall, o_as_rise, ea_fall, ea_ds, ea_rise); end
      n_vec++; if (o_rdata !== exp_rdata || o_port !== sport || o_err !== 1'b0) begin n_err++; $display("FAIL rnd%0d_fields: got %h/%b/%b expected %h/%b/0", i, o_rdata, o_port, o_err, exp_rdata, sport); end
      n_vec++; if (o_bus_bad || o_busy_bad) begin n_err++; $display("FAIL rnd%0d_bus: got bus=%b busy=%b expected 0/0", i, o_bus_bad, o_busy_bad); end
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; exp_rdata = 32'h0;
    RST = 1'b1; REQ_VALID = 1'b0; REQ_ADDR = '0; REQ_RW = 1'b1; REQ_SIZ = 2'b00; REQ_WDATA = 32'h0;
    D_IN = 32'h0; DSACK0_n = 1'b1; DSACK1_n = 1'b1;
    test_reset();
    test_read();
    test_write();
    test_port_width();
    test_back_to_back();
    test_rst_in_wait();
`ifdef BUS_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
